// File: rtl/vending_pkg.sv
// Shared types for the change dispenser: coin encoding, coin values,
// dispenser FSM states and the queued request record.
package vending_pkg;

  // Width of the change amount carried in a queued request.
  localparam int PKG_DATA_W = 8;

  // Coin encoding as presented on coin_type, largest coin first.
  typedef enum logic [1:0] {
    C50 = 2'd0,
    C10 = 2'd1,
    C5  = 2'd2,
    C1  = 2'd3
  } coin_e;

  // Face value of each coin, indexed by coin_e.
  localparam logic [7:0] COIN_VAL [4] = '{8'd50, 8'd10, 8'd5, 8'd1};

  // Dispenser sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROD = 2'd1,
    COIN = 2'd2,
    DONE = 2'd3
  } disp_state_e;

  // One captured transaction: product id and change still owed.
  typedef struct packed {
    logic [1:0]            pid;
    logic [PKG_DATA_W-1:0] amt;
  } req_t;

endpackage

// File: rtl/change_fifo.sv
// Synchronous request queue of req_t entries. A pop on the same edge as a
// push into a full queue frees the slot, so that push is accepted.
module change_fifo
  import vending_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  req_t          din,
  output req_t          dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  req_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: captures Vending core results, queues them, releases
// the product and then pays change greedily one coin per handshake.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int DATA_W     = PKG_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MO,
  input  logic [1:0]        PO,
  output logic              prod_valid,
  output logic [1:0]        prod_id,
  input  logic              prod_ready,
  output logic              coin_valid,
  output logic [1:0]        coin_type,
  input  logic              coin_ready,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Largest coin not exceeding the remaining amount.
  function automatic coin_e coin_sel(input logic [DATA_W-1:0] a);
    if (a >= DATA_W'(50)) return C50;
    if (a >= DATA_W'(10)) return C10;
    if (a >= DATA_W'(5))  return C5;
    return C1;
  endfunction

  // Face value of a coin at the amount width.
  function automatic logic [DATA_W-1:0] coin_val(input coin_e c);
    return DATA_W'(COIN_VAL[c]);
  endfunction

  logic              vld_p0;
  req_t              req_p0;
  req_t              head;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_n;
  logic              pop;
  logic              push_ok;
  disp_state_e       state;
  disp_state_e       state_n;
  logic [1:0]        pid;
  logic [DATA_W-1:0] amt;
  coin_e             coin_cur;
  logic [DATA_W-1:0] amt_sub;

  // Stage p0: register nonzero Vending core results for the queue.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= (MO != '0) || (PO != 2'd0);
  end

  // Stage p0 payload, held without reset.
  always_ff @(posedge clk) begin
    req_p0.pid <= PO;
    req_p0.amt <= MO;
  end

  assign pop     = (state == IDLE) && !empty;
  assign push_ok = vld_p0 && (!full || pop);

  change_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (vld_p0),
    .pop  (pop),
    .din  (req_p0),
    .dout (head),
    .full (full),
    .empty(empty),
    .level(level)
  );

  // Queue occupancy after the current edge, used for the registered busy flag.
  always_comb begin
    level_n = level;
    if (push_ok && !pop)      level_n = level + LW'(1);
    else if (!push_ok && pop) level_n = level - LW'(1);
  end

  assign coin_cur = coin_sel(amt);
  assign amt_sub  = amt - coin_val(coin_cur);

  // Next-state and handshake decode; valid/payload follow state and amt only.
  always_comb begin
    state_n    = state;
    prod_valid = 1'b0;
    prod_id    = 2'd0;
    coin_valid = 1'b0;
    coin_type  = 2'd0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head.pid != 2'd0)     state_n = PROD;
          else if (head.amt != '0)  state_n = COIN;
          else                      state_n = DONE;
        end
      end
      PROD: begin
        prod_valid = 1'b1;
        prod_id    = pid;
        if (prod_ready) state_n = (amt != '0) ? COIN : DONE;
      end
      COIN: begin
        coin_valid = 1'b1;
        coin_type  = coin_cur;
        if (coin_ready && (amt_sub == '0)) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any transaction in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Transaction registers: load on pop, decrement by each paid coin.
  always_ff @(posedge clk) begin
    if (pop) begin
      pid <= head.pid;
      amt <= head.amt;
    end else if (coin_valid && coin_ready) begin
      amt <= amt_sub;
    end
  end

  // Registered status: done pulse, busy, and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      busy <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= (state_n == DONE);
      busy <= (state_n != IDLE) || (level_n != '0);
      if (vld_p0 && full && !pop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed scenarios plus random
// traffic, with expected hopper events produced by a greedy change model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] MO = 8'd0;
  logic [1:0] PO = 2'd0;
  logic       prod_ready = 1'b0;
  logic       coin_ready = 1'b0;
  logic       prod_valid;
  logic [1:0] prod_id;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       done;
  logic       busy;
  logic       ovf;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int outstanding = 0;
  int coin_cnt = 0;
  int prod_cnt = 0;
  int done_cnt = 0;
  bit rnd_ready = 1'b0;

  logic       pv_q = 1'b0, pr_q = 1'b0, cv_q = 1'b0, cr_q = 1'b0;
  logic [1:0] pid_q = 2'd0, ct_q = 2'd0;

  change_dispenser #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .MO(MO), .PO(PO),
    .prod_valid(prod_valid), .prod_id(prod_id), .prod_ready(prod_ready),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Event codes: product id (1..3), 4 + coin code, 8 = done.
  task automatic sb_pop(input string name, input int act);
    int e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: unexpected event %0d with empty scoreboard", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // Expected event sequence of one transaction from the dispensing rules.
  function automatic void model_push(input int pid, input int amt);
    int vals[4] = '{50, 10, 5, 1};
    int a;
    int c;
    a = amt;
    if (pid != 0) exp_q.push_back(pid);
    while (a > 0) begin
      c = 0;
      while (vals[c] > a) c++;
      exp_q.push_back(4 + c);
      a -= vals[c];
    end
    exp_q.push_back(8);
  endfunction

  // Monitor: observe transfers and done pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prod_valid || coin_valid)
        check("valid_exclusive", int'(prod_valid & coin_valid), 0);
      if (pv_q && !pr_q && prod_valid) check("prod_id_stable", int'(prod_id), int'(pid_q));
      if (cv_q && !cr_q && coin_valid) check("coin_type_stable", int'(coin_type), int'(ct_q));
      if (prod_valid && prod_ready) begin
        sb_pop("prod_event", int'(prod_id));
        prod_cnt++;
      end
      if (coin_valid && coin_ready) begin
        sb_pop("coin_event", 4 + int'(coin_type));
        coin_cnt++;
      end
      if (done) begin
        sb_pop("done_event", 8);
        done_cnt++;
        if (outstanding > 0) outstanding--;
      end
    end
    pv_q  = prod_valid;
    pr_q  = prod_ready;
    pid_q = prod_id;
    cv_q  = coin_valid;
    cr_q  = coin_ready;
    ct_q  = coin_type;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) begin
      prod_ready = ($urandom_range(0, 3) != 0);
      coin_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic issue(input int p, input int m, input bit acc);
    PO = 2'(p);
    MO = 8'(m);
    if (acc) begin
      model_push(p, m);
      outstanding++;
    end
    tick();
    PO = 2'd0;
    MO = 8'd0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((outstanding != 0 || busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, int'(n >= budget), 0);
  endtask

  task automatic wait_valid(input string name, input bit want_coin);
    int n;
    n = 0;
    @(negedge clk);
    while (!(want_coin ? coin_valid : prod_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wait"}, int'(n >= 50), 0);
  endtask

  task automatic clear_counts();
    coin_cnt = 0;
    prod_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int p, m;
    int n;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_prod_valid", int'(prod_valid), 0);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_prod_id", int'(prod_id), 0);
    check("rst_coin_type", int'(coin_type), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1: 87 change with product 2, plus input-to-valid latency.
    prod_ready = 1'b1;
    coin_ready = 1'b1;
    clear_counts();
    issue(2, 87, 1);
    @(negedge clk);
    check("lat_edge_k", int'(prod_valid), 0);
    @(negedge clk);
    check("lat_edge_k1", int'(prod_valid), 0);
    @(negedge clk);
    check("lat_edge_k2", int'(prod_valid), 1);
    wait_idle("t1", 200);
    check("t1_coins", coin_cnt, 7);
    check("t1_prods", prod_cnt, 1);
    check("t1_dones", done_cnt, 1);

    // 2: product only, done one cycle after the product transfer.
    clear_counts();
    issue(1, 0, 1);
    wait_valid("t2_prod", 1'b0);
    @(negedge clk);
    check("t2_done_after_prod", int'(done), 1);
    wait_idle("t2", 200);
    check("t2_coins", coin_cnt, 0);
    check("t2_prods", prod_cnt, 1);

    // 3: 255 change, no product.
    clear_counts();
    issue(0, 255, 1);
    wait_idle("t3", 200);
    check("t3_coins", coin_cnt, 6);
    check("t3_prods", prod_cnt, 0);
    check("t3_dones", done_cnt, 1);

    // 4: first coin stalled for 3 cycles, payload held.
    coin_ready = 1'b0;
    issue(3, 16, 1);
    wait_valid("t4_coin", 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", int'(coin_valid), 1);
      check("t4_hold_type", int'(coin_type), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    coin_ready = 1'b1;
    wait_idle("t4", 200);

    // 5: overflow with the product hopper stalled.
    clear_counts();
    prod_ready = 1'b0;
    for (int i = 0; i < 6; i++) issue(1 + (i % 3), $urandom_range(0, 120), (i < 5));
    repeat (3) tick();
    @(negedge clk);
    check("t5_ovf_set", int'(ovf), 1);
    check("t5_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    prod_ready = 1'b1;
    wait_idle("t5", 1000);
    check("t5_dones", done_cnt, 5);
    check("t5_ovf_sticky", int'(ovf), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ovf_cleared", int'(ovf), 0);
    tick();

    // 6: reset in the middle of paying 60.
    coin_ready = 1'b0;
    issue(0, 60, 1);
    wait_valid("t6_coin", 1'b1);
    @(posedge clk);
    #1;
    coin_ready = 1'b1;
    @(posedge clk);
    #1;
    coin_ready = 1'b0;
    @(negedge clk);
    check("t6_partial_type", int'(coin_type), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    outstanding = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_prod_valid", int'(prod_valid), 0);
    check("t6_coin_valid", int'(coin_valid), 0);
    check("t6_coin_type", int'(coin_type), 0);
    check("t6_done", int'(done), 0);
    check("t6_busy", int'(busy), 0);
    clear_counts();
    coin_ready = 1'b1;
    prod_ready = 1'b1;
    repeat (20) tick();
    check("t6_no_coins", coin_cnt, 0);
    check("t6_still_idle", int'(busy), 0);

    // Random traffic with random hopper readiness, kept below queue capacity.
    rnd_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      n = 0;
      while (outstanding >= 4 && n < 500) begin
        tick();
        n++;
      end
      if (n >= 500) check("rand_backlog_timeout", 1, 0);
      repeat ($urandom_range(0, 3)) tick();
      p = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0:       m = 255;
        1:       m = 0;
        default: m = $urandom_range(0, 255);
      endcase
      if (p == 0 && m == 0) m = $urandom_range(1, 255);
      issue(p, m, 1);
    end
    wait_idle("rand", 5000);
    rnd_ready = 1'b0;
    check("rand_no_ovf", int'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
